// File: rtl/riscv_ex_mem_buf_pkg.sv
// riscv_ex_mem_buf_pkg
//   Shared definitions for the EX->MEM elastic pipeline register:
//   datapath width, the load opcode used for hazard detection, the packed
//   181-bit execute bundle, the occupancy encoding of the two-entry skid
//   buffer and small decode helpers for forwarding / load-use detection.
package riscv_ex_mem_buf_pkg;

  localparam int         XLEN     = 32;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  // Field order here fixes the packed layout carried through the buffer.
  typedef struct packed {
    logic            reg_wr_en;
    logic [1:0]      src_rd;
    logic            mem_wr_en;
    logic [2:0]      funct3;
    logic [6:0]      opcode;
    logic [1:0]      src_pc;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pcimm;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rd;
  } ex_bundle_t;

  localparam int BUNDLE_W = $bits(ex_bundle_t);

  // Occupancy is just {main_valid, skid_valid}; 2'b01 can never occur.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b10,
    OCC_TWO   = 2'b11
  } occ_e;

  // Head entry will write a real architectural register (x0 never forwards).
  function automatic logic fwd_enable(input logic valid, input ex_bundle_t b);
    return valid & b.reg_wr_en & (b.rd != 5'd0);
  endfunction

  // Head entry is a load whose data is not available until MEM completes.
  function automatic logic load_pending(input logic valid, input ex_bundle_t b);
    return valid & (b.opcode == OPC_LOAD);
  endfunction

endpackage

// File: rtl/riscv_skid_reg.sv
// riscv_skid_reg
//   Width-parameterised two-entry skid buffer with flush. The main register
//   is the head presented downstream; the skid register catches one extra
//   entry when downstream stalls, so the upstream ready can be a flop.
//   Ports:
//     i_clk, i_rst (sync, active-high), i_flush (drop all entries)
//     i_valid / o_ready / i_data  : upstream handshake
//     o_valid / i_ready / o_data  : downstream handshake (head entry)
module riscv_skid_reg
  import riscv_ex_mem_buf_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         ready_q, ready_d;
  logic         in_fire;
  logic         out_fire;
  occ_e         occ;

  assign in_fire  = i_valid & ready_q;
  assign out_fire = main_valid_q & i_ready;
  assign occ      = occ_e'({main_valid_q, skid_valid_q});

  // Next-state and next-payload selection for head and skid entries.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (i_flush) begin
      // Flush wins over both fires; a same-cycle out_fire still completes
      // downstream because the consumer samples the head before this edge.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = i_data;
          end else begin
            main_valid_d = 1'b0;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = i_data;
          end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = i_data;
          end else if (out_fire) begin
            main_valid_d = 1'b0;
          end else begin
            main_valid_d = 1'b1;
          end
        end
        OCC_TWO: begin
          // ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end else begin
            skid_valid_d = 1'b1;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
    // Upstream ready is a pure function of the next skid occupancy, so it
    // never depends combinationally on i_ready.
    ready_d = ~skid_valid_d;
  end

  // State and payload registers; payload cleared on reset for X-free sim.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= {W{1'b0}};
      skid_data_q  <= {W{1'b0}};
      ready_q      <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = main_valid_q;
  assign o_data  = main_data_q;

endmodule

// File: rtl/riscv_ex_mem_buf.sv
// riscv_ex_mem_buf
//   Elastic EX->MEM pipeline register. Packs the execute bundle, holds it in
//   a two-entry skid buffer and presents the head entry to MEM, together with
//   forwarding and load-use hazard information for the EX stage.
//   Ports:
//     i_clk, i_rst (sync, active-high), i_flush (redirect: drop everything)
//     i_EX_valid / o_EX_ready / i_EX_*   : execute-side handshake + bundle
//     o_MEM_valid / i_MEM_ready / o_MEM_*: memory-side handshake + head bundle
//     o_MEM_fwd_en/_rd/_data             : head result for operand forwarding
//     o_MEM_load_pending                 : head is a load (load-use stall)
module riscv_ex_mem_buf
  import riscv_ex_mem_buf_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_EX_valid,
  output logic            o_EX_ready,
  input  logic            i_EX_reg_wr_en,
  input  logic [1:0]      i_EX_src_rd,
  input  logic            i_EX_mem_wr_en,
  input  logic [2:0]      i_EX_funct3,
  input  logic [6:0]      i_EX_opcode,
  input  logic [1:0]      i_EX_src_pc,
  input  logic [XLEN-1:0] i_EX_fwd_b,
  input  logic [XLEN-1:0] i_EX_alu_out,
  input  logic [XLEN-1:0] i_EX_imm,
  input  logic [XLEN-1:0] i_EX_pcimm,
  input  logic [XLEN-1:0] i_EX_pc4,
  input  logic [4:0]      i_EX_rd,
  output logic            o_MEM_valid,
  input  logic            i_MEM_ready,
  output logic            o_MEM_reg_wr_en,
  output logic [1:0]      o_MEM_src_rd,
  output logic            o_MEM_mem_wr_en,
  output logic [2:0]      o_MEM_funct3,
  output logic [6:0]      o_MEM_opcode,
  output logic [1:0]      o_MEM_src_pc,
  output logic [XLEN-1:0] o_MEM_fwd_b,
  output logic [XLEN-1:0] o_MEM_alu_out,
  output logic [XLEN-1:0] o_MEM_imm,
  output logic [XLEN-1:0] o_MEM_pcimm,
  output logic [XLEN-1:0] o_MEM_pc4,
  output logic [4:0]      o_MEM_rd,
  output logic            o_MEM_fwd_en,
  output logic [4:0]      o_MEM_fwd_rd,
  output logic [XLEN-1:0] o_MEM_fwd_data,
  output logic            o_MEM_load_pending
);

  ex_bundle_t in_bundle;
  ex_bundle_t head;
  logic       head_valid;

  assign in_bundle = '{
    reg_wr_en: i_EX_reg_wr_en,
    src_rd:    i_EX_src_rd,
    mem_wr_en: i_EX_mem_wr_en,
    funct3:    i_EX_funct3,
    opcode:    i_EX_opcode,
    src_pc:    i_EX_src_pc,
    fwd_b:     i_EX_fwd_b,
    alu_out:   i_EX_alu_out,
    imm:       i_EX_imm,
    pcimm:     i_EX_pcimm,
    pc4:       i_EX_pc4,
    rd:        i_EX_rd
  };

  riscv_skid_reg #(
    .W(BUNDLE_W)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_EX_valid),
    .o_ready (o_EX_ready),
    .i_data  (in_bundle),
    .o_valid (head_valid),
    .i_ready (i_MEM_ready),
    .o_data  (head)
  );

  assign o_MEM_valid     = head_valid;
  assign o_MEM_reg_wr_en = head.reg_wr_en;
  assign o_MEM_src_rd    = head.src_rd;
  assign o_MEM_mem_wr_en = head.mem_wr_en;
  assign o_MEM_funct3    = head.funct3;
  assign o_MEM_opcode    = head.opcode;
  assign o_MEM_src_pc    = head.src_pc;
  assign o_MEM_fwd_b     = head.fwd_b;
  assign o_MEM_alu_out   = head.alu_out;
  assign o_MEM_imm       = head.imm;
  assign o_MEM_pcimm     = head.pcimm;
  assign o_MEM_pc4       = head.pc4;
  assign o_MEM_rd        = head.rd;

  // Hazard decode is derived only from the head flops, so it is glitch-free
  // and needs no state of its own.
  assign o_MEM_fwd_en       = fwd_enable(head_valid, head);
  assign o_MEM_fwd_rd       = head.rd;
  assign o_MEM_fwd_data     = head.alu_out;
  assign o_MEM_load_pending = load_pending(head_valid, head);

endmodule

// File: tb/tb_riscv_ex_mem_buf.sv
module tb_riscv_ex_mem_buf;
  import riscv_ex_mem_buf_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, ex_valid, mem_ready;
  ex_bundle_t ex_b;
  ex_bundle_t obs;
  logic ex_ready, m_valid, m_fwd_en, m_load_pending;
  logic m_reg_wr_en, m_mem_wr_en;
  logic [1:0] m_src_rd, m_src_pc;
  logic [2:0] m_funct3;
  logic [6:0] m_opcode;
  logic [31:0] m_fwd_b, m_alu_out, m_imm, m_pcimm, m_pc4, m_fwd_data;
  logic [4:0] m_rd, m_fwd_rd;

  int n_cmp = 0;
  int n_fail = 0;
  ex_bundle_t mq[$];          // reference FIFO, capacity 2, head at index 0
  logic last_in_fire = 1'b0;

  always #5 clk = ~clk;

  riscv_ex_mem_buf dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_EX_valid(ex_valid), .o_EX_ready(ex_ready),
    .i_EX_reg_wr_en(ex_b.reg_wr_en), .i_EX_src_rd(ex_b.src_rd),
    .i_EX_mem_wr_en(ex_b.mem_wr_en), .i_EX_funct3(ex_b.funct3),
    .i_EX_opcode(ex_b.opcode), .i_EX_src_pc(ex_b.src_pc),
    .i_EX_fwd_b(ex_b.fwd_b), .i_EX_alu_out(ex_b.alu_out),
    .i_EX_imm(ex_b.imm), .i_EX_pcimm(ex_b.pcimm),
    .i_EX_pc4(ex_b.pc4), .i_EX_rd(ex_b.rd),
    .o_MEM_valid(m_valid), .i_MEM_ready(mem_ready),
    .o_MEM_reg_wr_en(m_reg_wr_en), .o_MEM_src_rd(m_src_rd),
    .o_MEM_mem_wr_en(m_mem_wr_en), .o_MEM_funct3(m_funct3),
    .o_MEM_opcode(m_opcode), .o_MEM_src_pc(m_src_pc),
    .o_MEM_fwd_b(m_fwd_b), .o_MEM_alu_out(m_alu_out),
    .o_MEM_imm(m_imm), .o_MEM_pcimm(m_pcimm),
    .o_MEM_pc4(m_pc4), .o_MEM_rd(m_rd),
    .o_MEM_fwd_en(m_fwd_en), .o_MEM_fwd_rd(m_fwd_rd),
    .o_MEM_fwd_data(m_fwd_data), .o_MEM_load_pending(m_load_pending)
  );

  assign obs = {m_reg_wr_en, m_src_rd, m_mem_wr_en, m_funct3, m_opcode, m_src_pc,
                m_fwd_b, m_alu_out, m_imm, m_pcimm, m_pc4, m_rd};

  function automatic ex_bundle_t rand_bundle();
    ex_bundle_t b;
    b.reg_wr_en = 1'($urandom_range(0, 1));
    b.src_rd    = 2'($urandom);
    b.mem_wr_en = 1'($urandom_range(0, 1));
    b.funct3    = 3'($urandom);
    b.opcode    = ($urandom_range(0, 3) == 0) ? 7'b0000011 : 7'($urandom);
    b.src_pc    = 2'($urandom);
    b.fwd_b     = $urandom;
    b.alu_out   = $urandom;
    b.imm       = $urandom;
    b.pcimm     = $urandom;
    b.pc4       = $urandom;
    b.rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    return b;
  endfunction

  // One clock: FIFO model of a 2-deep elastic buffer, then settle for sampling.
  task automatic tick();
    logic in_f, out_f;
    in_f  = ex_valid && (mq.size() < 2);
    out_f = (mq.size() > 0) && mem_ready;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (out_f) mq.delete(0);
      if (in_f) mq.push_back(ex_b);
    end
    last_in_fire = in_f && !rst && !flush;
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    mem_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    ex_b = rand_bundle();
    rst = 1'b1; ex_valid = 1'b1;
    tick();
    rst = 1'b0; ex_valid = 1'b0;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ex_ready); end
    n_cmp++; if (m_fwd_en !== 1'b0 || m_load_pending !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got=%b%b exp=00", m_fwd_en, m_load_pending); end
    n_cmp++; if (obs !== {BUNDLE_W{1'b0}}) begin n_fail++; $display("FAIL reset_payload got=%h exp=0", obs); end
  endtask

  task automatic test_streaming();
    idle_inputs();
    mem_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ex_b = rand_bundle();
      ex_b.alu_out = 32'(i);
      ex_valid = 1'b1;
      tick();
      n_cmp++; if (m_valid !== 1'b1 || m_alu_out !== 32'(i)) begin n_fail++; $display("FAIL stream_head i=%0d got v=%b alu=%0d exp v=1 alu=%0d", i, m_valid, m_alu_out, i); end
      n_cmp++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, ex_ready); end
      n_cmp++; if (obs !== mq[0]) begin n_fail++; $display("FAIL stream_payload i=%0d got=%h exp=%h", i, obs, mq[0]); end
    end
    ex_valid = 1'b0;
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_stall_skid();
    logic [31:0] seen[$];
    idle_inputs();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_b = rand_bundle();
      ex_b.alu_out = 32'(10 + i);
      ex_valid = 1'b1;
      if (i == 1) mem_ready = 1'b0;   // stall starting with the cycle 11 is offered
      while (1) begin
        tick();
        if (last_in_fire || i == 2) break;
      end
      if (i == 1) begin
        n_cmp++; if (m_alu_out !== 32'd10 || ex_ready !== 1'b0) begin n_fail++; $display("FAIL skid_full got alu=%0d rdy=%b exp alu=10 rdy=0", m_alu_out, ex_ready); end
      end
    end
    // 12 is offered but must be held off while both entries are full
    tick();
    n_cmp++; if (m_alu_out !== 32'd10 || ex_ready !== 1'b0 || mq.size() != 2) begin n_fail++; $display("FAIL skid_hold got alu=%0d rdy=%b exp alu=10 rdy=0", m_alu_out, ex_ready); end
    mem_ready = 1'b1;
    seen.push_back(m_alu_out);
    for (int c = 0; c < 6; c++) begin
      if (last_in_fire) ex_valid = 1'b0;
      tick();
      if (m_valid === 1'b1 && m_alu_out !== seen[$]) seen.push_back(m_alu_out);
    end
    n_cmp++; if (seen.size() != 3 || seen[0] !== 32'd10 || seen[1] !== 32'd11 || seen[2] !== 32'd12) begin n_fail++; $display("FAIL skid_order got n=%0d exp 10,11,12", seen.size()); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL skid_drained got=%b exp=0", m_valid); end
  endtask

  task automatic test_flush_two();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      ex_b = rand_bundle(); ex_b.alu_out = 32'(20 + i); ex_valid = 1'b1;
      tick();
    end
    n_cmp++; if (ex_ready !== 1'b0 || m_alu_out !== 32'd20) begin n_fail++; $display("FAIL flush_pre got rdy=%b alu=%0d exp rdy=0 alu=20", ex_ready, m_alu_out); end
    ex_b = rand_bundle(); ex_b.alu_out = 32'd22; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (m_valid !== 1'b0 || ex_ready !== 1'b1) begin n_fail++; $display("FAIL flush_two got v=%b rdy=%b exp v=0 rdy=1", m_valid, ex_ready); end
    ex_valid = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost c=%0d got v=%b alu=%0d exp v=0", c, m_valid, m_alu_out); end
    end
  endtask

  task automatic test_forwarding();
    idle_inputs();
    ex_b = rand_bundle(); ex_b.rd = 5'd5; ex_b.reg_wr_en = 1'b1; ex_b.alu_out = 32'hDEADBEEF;
    ex_valid = 1'b1;
    tick();
    n_cmp++; if (m_fwd_en !== 1'b1 || m_fwd_rd !== 5'd5 || m_fwd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fwd_rd5 got en=%b rd=%0d data=%h exp en=1 rd=5 data=deadbeef", m_fwd_en, m_fwd_rd, m_fwd_data); end
    mem_ready = 1'b1;
    ex_b = rand_bundle(); ex_b.rd = 5'd0; ex_b.reg_wr_en = 1'b1;
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_fwd_en !== 1'b0) begin n_fail++; $display("FAIL fwd_rd0 got v=%b en=%b exp v=1 en=0", m_valid, m_fwd_en); end
    ex_b = rand_bundle(); ex_b.rd = 5'd7; ex_b.reg_wr_en = 1'b0;
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_fwd_en !== 1'b0) begin n_fail++; $display("FAIL fwd_nowr got v=%b en=%b exp v=1 en=0", m_valid, m_fwd_en); end
    drain();
  endtask

  task automatic test_load_hazard();
    idle_inputs();
    mem_ready = 1'b1; ex_valid = 1'b1;
    ex_b = rand_bundle(); ex_b.opcode = 7'b0000011;
    tick();
    n_cmp++; if (m_load_pending !== 1'b1) begin n_fail++; $display("FAIL load_op got=%b exp=1", m_load_pending); end
    ex_b = rand_bundle(); ex_b.opcode = 7'b0110011;
    tick();
    n_cmp++; if (m_load_pending !== 1'b0) begin n_fail++; $display("FAIL alu_op got=%b exp=0", m_load_pending); end
    drain();
    n_cmp++; if (m_load_pending !== 1'b0) begin n_fail++; $display("FAIL load_empty got=%b exp=0", m_load_pending); end
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    ex_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin ex_b = rand_bundle(); tick(); end
    ex_b = rand_bundle(); rst = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (m_valid !== 1'b0 || ex_ready !== 1'b1 || m_fwd_en !== 1'b0 || m_load_pending !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got v=%b rdy=%b en=%b lp=%b exp 0100", m_valid, ex_ready, m_fwd_en, m_load_pending); end
    n_cmp++; if (obs !== {BUNDLE_W{1'b0}}) begin n_fail++; $display("FAIL rst_mid_payload got=%h exp=0", obs); end
  endtask

  task automatic test_random();
    logic exp_fwd, exp_ld;
    idle_inputs();
    last_in_fire = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(ex_valid && !last_in_fire)) begin
        ex_valid = ($urandom_range(0, 3) != 0);
        ex_b = rand_bundle();
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      tick();
      exp_fwd = (mq.size() > 0) && mq[0].reg_wr_en && (mq[0].rd != 5'd0);
      exp_ld  = (mq.size() > 0) && (mq[0].opcode == 7'b0000011);
      n_cmp++; if (m_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%0d", c, m_valid, mq.size() > 0); end
      n_cmp++; if (ex_ready !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%0d", c, ex_ready, mq.size() < 2); end
      n_cmp++; if (m_fwd_en !== exp_fwd || m_load_pending !== exp_ld) begin n_fail++; $display("FAIL rnd_hazard c=%0d got=%b%b exp=%b%b", c, m_fwd_en, m_load_pending, exp_fwd, exp_ld); end
      if (mq.size() > 0) begin
        n_cmp++; if (obs !== mq[0] || m_fwd_rd !== mq[0].rd || m_fwd_data !== mq[0].alu_out) begin n_fail++; $display("FAIL rnd_payload c=%0d got=%h exp=%h", c, obs, mq[0]); end
      end
    end
    drain();
  endtask

  initial begin
    idle_inputs();
    ex_b = '{default: 1'b0};
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush_two();
    test_forwarding();
    test_load_hazard();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
